// File: rtl/mux_n_pkg.sv
// Shared definitions for the registered N-way selector (mux_n_reg).
// Optional feature macro: MUX_N_PARITY_EN (adds the dout_par output).
package mux_n_pkg;

  // Selector FSM encoding: ST_IDLE=0, ST_SWITCH=1, ST_LIVE=2
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWITCH = 2'd1,
    ST_LIVE   = 2'd2
  } state_t;

  // Legal range for the CHANNELS parameter
  localparam int unsigned CH_MIN = 2;
  localparam int unsigned CH_MAX = 16;

endpackage : mux_n_pkg

// File: rtl/mux_n_comb.sv
// Purely combinational CHANNELS:1 word selector; out-of-range select yields zero.
module mux_n_comb #(
  parameter  int unsigned WIDTH    = 32,
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          y
);

  // Pick channel sel out of the flattened input bus
  always_comb begin
    y = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (sel == SEL_W'(k)) y = din[k*WIDTH +: WIDTH];
    end
  end

endmodule : mux_n_comb

// File: rtl/mux_n_reg.sv
// Registered N-way datapath selector with latched select, one-cycle
// switch-over blanking and output hold.
// Optional feature macro: MUX_N_PARITY_EN (registered even parity on dout_par).
module mux_n_reg
  import mux_n_pkg::*;
#(
  parameter  int unsigned WIDTH    = 32,
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      sel_vld,
  input  logic                      hold,
  output logic [WIDTH-1:0]          dout,
  output logic                      dout_vld,
  output logic [SEL_W-1:0]          sel_q,
`ifdef MUX_N_PARITY_EN
  output logic                      dout_par,
`endif
  output logic                      sel_err
);

  if (CHANNELS < CH_MIN || CHANNELS > CH_MAX) begin : g_bad_channels
    $error("mux_n_reg: CHANNELS out of range");
  end

  localparam logic [SEL_W:0] CH_LIM = (SEL_W + 1)'(CHANNELS);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               dout_vld_q, dout_vld_d;
  logic               sel_err_q, sel_err_d;
  logic [WIDTH-1:0]   mux_y;
  logic               in_range;
  logic               req_ok;
`ifdef MUX_N_PARITY_EN
  logic               par_q, par_d;
`endif

  mux_n_comb #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) u_mux (
    .din (din),
    .sel (sel_q),
    .y   (mux_y)
  );

  // Next-state, select latch, output data and error pulse
  always_comb begin
    in_range   = ({1'b0, sel} < CH_LIM);
    req_ok     = sel_vld & in_range;
    sel_err_d  = sel_vld & ~in_range;
    state_d    = state_q;
    sel_d      = sel_q;
    dout_d     = dout_q;
    dout_vld_d = dout_vld_q;
    unique case (state_q)
      ST_IDLE: begin
        dout_vld_d = 1'b0;
        if (req_ok) begin
          sel_d   = sel;
          state_d = ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        dout_vld_d = 1'b0;
        if (req_ok) sel_d = sel;
        else        state_d = ST_LIVE;
      end
      ST_LIVE: begin
        if (!hold) begin
          dout_d     = mux_y;
          dout_vld_d = 1'b1;
        end
        // A real channel change blanks dout_vld even while hold is set
        if (req_ok && (sel != sel_q)) begin
          sel_d      = sel;
          state_d    = ST_SWITCH;
          dout_vld_d = 1'b0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        dout_vld_d = 1'b0;
      end
    endcase
`ifdef MUX_N_PARITY_EN
    par_d = ^dout_d;
`endif
  end

  // FSM and all output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      sel_err_q  <= 1'b0;
`ifdef MUX_N_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      sel_err_q  <= sel_err_d;
`ifdef MUX_N_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign sel_err  = sel_err_q;
`ifdef MUX_N_PARITY_EN
  assign dout_par = par_q;
`endif

endmodule : mux_n_reg

// File: tb/tb_mux_n_reg.sv
// Bench for mux_n_reg: 4-channel instance driven from a vector table with a
// scoreboard queue, plus a 3-channel instance for the out-of-range select.
module tb_mux_n_reg;

  typedef struct {
    logic [31:0] base;   // channel k carries base + k
    logic [1:0]  sel;
    logic        vld;
    logic        hold;
    logic [31:0] e_dout;
    logic        e_vld;
    logic [1:0]  e_sel;
    logic        e_err;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic [127:0] din4 = '0;
  logic [1:0]   sel4 = '0;
  logic         vld4 = 1'b0;
  logic         hold4 = 1'b0;
  logic [31:0]  dout4;
  logic         dvld4;
  logic [1:0]   selq4;
  logic         err4;
  logic         par4;

  logic [95:0]  din3 = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
  logic [1:0]   sel3 = '0;
  logic         vld3 = 1'b0;
  logic         hold3 = 1'b0;
  logic [31:0]  dout3;
  logic         dvld3;
  logic [1:0]   selq3;
  logic         err3;
  logic         par3;

  int unsigned  checks = 0;
  int unsigned  errors = 0;
  vec_t         exp_q[$];
  vec_t         tbl[18];

  always #5 clk = ~clk;

  mux_n_reg #(.WIDTH(32), .CHANNELS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .din(din4), .sel(sel4), .sel_vld(vld4),
    .hold(hold4), .dout(dout4), .dout_vld(dvld4), .sel_q(selq4),
`ifdef MUX_N_PARITY_EN
    .dout_par(par4),
`endif
    .sel_err(err4)
  );

  mux_n_reg #(.WIDTH(32), .CHANNELS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .din(din3), .sel(sel3), .sel_vld(vld3),
    .hold(hold3), .dout(dout3), .dout_vld(dvld3), .sel_q(selq3),
`ifdef MUX_N_PARITY_EN
    .dout_par(par3),
`endif
    .sel_err(err3)
  );

`ifndef MUX_N_PARITY_EN
  assign par4 = 1'b0;
  assign par3 = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] base, input logic [1:0] sel,
                              input logic vld, input logic hold,
                              input logic [31:0] e_dout, input logic e_vld,
                              input logic [1:0] e_sel, input logic e_err);
    vec_t v;
    v.base = base; v.sel = sel; v.vld = vld; v.hold = hold;
    v.e_dout = e_dout; v.e_vld = e_vld; v.e_sel = e_sel; v.e_err = e_err;
    return v;
  endfunction

  // Drive one vector on the 4-channel DUT, then score the outputs after the edge
  task automatic step(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    for (int k = 0; k < 4; k++) din4[k*32 +: 32] = v.base + 32'(k);
    sel4  = v.sel;
    vld4  = v.vld;
    hold4 = v.hold;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1 at vector %0d", idx);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("v%0d dout", idx), dout4, e.e_dout);
      chk($sformatf("v%0d dout_vld", idx), 32'(dvld4), 32'(e.e_vld));
      chk($sformatf("v%0d sel_q", idx), 32'(selq4), 32'(e.e_sel));
      chk($sformatf("v%0d sel_err", idx), 32'(err4), 32'(e.e_err));
`ifdef MUX_N_PARITY_EN
      chk($sformatf("v%0d dout_par", idx), 32'(par4), 32'(^e.e_dout));
`endif
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          base           sel  vld   hold  e_dout         e_vld e_sel e_err
    tbl[0]  = mk(32'hA5A5_0000, 2'd2, 1'b1, 1'b0, 32'h0,         1'b0, 2'd2, 1'b0);
    tbl[1]  = mk(32'hA5A5_0000, 2'd2, 1'b0, 1'b0, 32'h0,         1'b0, 2'd2, 1'b0);
    tbl[2]  = mk(32'hA5A5_0000, 2'd2, 1'b0, 1'b0, 32'hA5A5_0002, 1'b1, 2'd2, 1'b0);
    tbl[3]  = mk(32'hA5A5_0010, 2'd2, 1'b0, 1'b0, 32'hA5A5_0012, 1'b1, 2'd2, 1'b0);
    tbl[4]  = mk(32'hA5A5_0010, 2'd1, 1'b1, 1'b0, 32'hA5A5_0012, 1'b0, 2'd1, 1'b0);
    tbl[5]  = mk(32'hA5A5_0020, 2'd3, 1'b1, 1'b0, 32'hA5A5_0012, 1'b0, 2'd3, 1'b0);
    tbl[6]  = mk(32'hA5A5_0030, 2'd3, 1'b0, 1'b0, 32'hA5A5_0012, 1'b0, 2'd3, 1'b0);
    tbl[7]  = mk(32'hA5A5_0040, 2'd3, 1'b0, 1'b0, 32'hA5A5_0043, 1'b1, 2'd3, 1'b0);
    tbl[8]  = mk(32'hA5A5_0050, 2'd3, 1'b1, 1'b0, 32'hA5A5_0053, 1'b1, 2'd3, 1'b0);
    tbl[9]  = mk(32'hA5A5_0060, 2'd3, 1'b1, 1'b0, 32'hA5A5_0063, 1'b1, 2'd3, 1'b0);
    tbl[10] = mk(32'h0000_110E, 2'd3, 1'b0, 1'b0, 32'h0000_1111, 1'b1, 2'd3, 1'b0);
    tbl[11] = mk(32'h0000_221F, 2'd3, 1'b0, 1'b1, 32'h0000_1111, 1'b1, 2'd3, 1'b0);
    tbl[12] = mk(32'h0000_221F, 2'd3, 1'b0, 1'b1, 32'h0000_1111, 1'b1, 2'd3, 1'b0);
    tbl[13] = mk(32'h0000_221F, 2'd3, 1'b0, 1'b0, 32'h0000_2222, 1'b1, 2'd3, 1'b0);
    tbl[14] = mk(32'h0000_3330, 2'd0, 1'b1, 1'b1, 32'h0000_2222, 1'b0, 2'd0, 1'b0);
    tbl[15] = mk(32'h0000_3330, 2'd0, 1'b0, 1'b1, 32'h0000_2222, 1'b0, 2'd0, 1'b0);
    tbl[16] = mk(32'h0000_3330, 2'd0, 1'b0, 1'b1, 32'h0000_2222, 1'b0, 2'd0, 1'b0);
    tbl[17] = mk(32'h0000_3330, 2'd0, 1'b0, 1'b0, 32'h0000_3330, 1'b1, 2'd0, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst dout", dout4, 32'h0);
    chk("rst dout_vld", 32'(dvld4), 32'h0);
    chk("rst sel_q", 32'(selq4), 32'h0);
    chk("rst sel_err", 32'(err4), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // First select, rapid reselect, same-channel request, hold, switch under hold
    for (int i = 0; i < 18; i++) step(tbl[i], i);

    // Out-of-range request on the 3-channel instance
    @(negedge clk); sel3 = 2'd1; vld3 = 1'b1;
    @(posedge clk); #1;
    chk("c3 switch sel_q", 32'(selq3), 32'd1);
    chk("c3 switch dout_vld", 32'(dvld3), 32'd0);
    @(negedge clk); vld3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("c3 live dout", dout3, 32'h3333_0001);
    chk("c3 live dout_vld", 32'(dvld3), 32'd1);
    @(negedge clk); sel3 = 2'd3; vld3 = 1'b1;
    @(posedge clk); #1;
    chk("c3 oor sel_err", 32'(err3), 32'd1);
    chk("c3 oor sel_q", 32'(selq3), 32'd1);
    chk("c3 oor dout", dout3, 32'h3333_0001);
    chk("c3 oor dout_vld", 32'(dvld3), 32'd1);
    @(negedge clk); vld3 = 1'b0;
    @(posedge clk); #1;
    chk("c3 oor sel_err pulse", 32'(err3), 32'd0);
    chk("c3 oor still live", 32'(dvld3), 32'd1);
    chk("c3 oor sel_q kept", 32'(selq3), 32'd1);

    // Asynchronous reset while in SWITCH
    step(mk(32'h0000_3330, 2'd1, 1'b1, 1'b0, 32'h0000_3330, 1'b0, 2'd1, 1'b0), 100);
    #1 rst_n = 1'b0;
    #1;
    chk("arst dout", dout4, 32'h0);
    chk("arst dout_vld", 32'(dvld4), 32'h0);
    chk("arst sel_q", 32'(selq4), 32'h0);
    chk("arst sel_err", 32'(err4), 32'h0);
    chk("arst c3 dout", dout3, 32'h0);
    chk("arst c3 dout_vld", 32'(dvld3), 32'h0);
`ifdef MUX_N_PARITY_EN
    chk("arst dout_par", 32'(par4), 32'h0);
`endif
    @(negedge clk); vld4 = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    step(mk(32'h0000_3330, 2'd1, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0), 101);
    step(mk(32'h0000_3330, 2'd1, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0), 102);

    // Parity of a selected value (channel 2 = 7, then 3)
    step(mk(32'h0000_0005, 2'd2, 1'b1, 1'b0, 32'h0,         1'b0, 2'd2, 1'b0), 103);
    step(mk(32'h0000_0005, 2'd2, 1'b0, 1'b0, 32'h0,         1'b0, 2'd2, 1'b0), 104);
    step(mk(32'h0000_0005, 2'd2, 1'b0, 1'b0, 32'h0000_0007, 1'b1, 2'd2, 1'b0), 105);
    step(mk(32'h0000_0001, 2'd2, 1'b0, 1'b0, 32'h0000_0003, 1'b1, 2'd2, 1'b0), 106);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mux_n_reg
